// File: rtl/down_counter_scheduler.sv
// -----------------------------------------------------------------------------
// down_counter_scheduler
//
// Shares one W-bit loadable down counter among N requesters. The scheduler
// grants requesters round-robin, loads the winner's value into the counter,
// waits for the counter output to reach zero and returns a one-cycle done
// pulse to the owner. A watchdog aborts a grant whose counter never reaches
// zero. The scheduler is the only driver of the counter's ld/ldvalue.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-low reset
//   req      in   [N]    level request per requester
//   val      in   [N*W]  per-requester load value, requester i at val[i*W +: W]
//   gnt      out  [N]    one-hot owner of the counter, zero when idle
//   done     out  [N]    one-cycle pulse to the owner when its count completes
//   err      out         one-cycle pulse on watchdog timeout
//   busy     out         high while a grant is in progress (LOAD, WAIT, DONE)
//   ld       out         load strobe to the counter
//   ldvalue  out  [W]    load value to the counter, held between loads
//   dout     in   [W]    counter output
// -----------------------------------------------------------------------------
module down_counter_scheduler #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] val,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           err,
  output logic           busy,
  output logic           ld,
  output logic [W-1:0]   ldvalue,
  input  logic [W-1:0]   dout
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;
  localparam int W1  = W + 1;
  // A healthy counter reaches zero within 2^W WAIT cycles, so 2^W+1 nonzero
  // cycles means the counter is not following ld.
  localparam logic [W:0] WD_LIMIT = W1'((1 << W) + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  done_q, done_d;
  logic          err_q, err_d;
  logic          ld_q, ld_d;
  logic [W-1:0]  ldvalue_q, ldvalue_d;
  logic [IW-1:0] ptr_q, ptr_d;   // last requester that finished its turn
  logic [IW-1:0] own_q, own_d;   // index of the current owner
  logic [W:0]    wdog_q, wdog_d;

  logic [W-1:0]  val_arr [N];
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;

  always_comb begin
    for (int i = 0; i < N; i++) val_arr[i] = val[i*W +: W];
  end

  // Round-robin search starting one past the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand_sum = {1'b0, ptr_q} + IW1'(k);
      if (cand_sum >= IW1'(N)) cand_sum = cand_sum - IW1'(N);
      cand = cand_sum[IW-1:0];
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // NOTE: every _d gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    err_d     = 1'b0;
    ld_d      = 1'b0;
    ldvalue_d = ldvalue_q;
    ptr_d     = ptr_q;
    own_d     = own_q;
    wdog_d    = wdog_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_LOAD;
          own_d     = win_idx;
          gnt_d     = N'(1) << win_idx;
          ldvalue_d = val_arr[win_idx];
          ld_d      = 1'b1;
        end
      end

      S_LOAD: begin
        wdog_d = '0;
        if (!req[own_q]) begin
          // Owner withdrew: release silently but still move past it.
          gnt_d   = '0;
          ptr_d   = own_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Withdrawal wins over completion or timeout seen in the same cycle.
        if (!req[own_q]) begin
          gnt_d   = '0;
          ptr_d   = own_q;
          state_d = S_IDLE;
        end else if (dout == '0) begin
          done_d  = gnt_q;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + W1'(1);
          if (wdog_d == WD_LIMIT) begin
            err_d   = 1'b1;
            gnt_d   = '0;
            ptr_d   = own_q;
            state_d = S_IDLE;
          end
        end
      end

      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = own_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      ld_q      <= 1'b0;
      ldvalue_q <= '0;
      ptr_q     <= IW'(N - 1);   // requester 0 searched first after reset
      own_q     <= '0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ld_q      <= ld_d;
      ldvalue_q <= ldvalue_d;
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      wdog_q    <= wdog_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ld      = ld_q;
  assign ldvalue = ldvalue_q;
  assign busy    = (state_q != S_IDLE);

endmodule
